// File: rtl/arb_pkg.sv
// arb_pkg: shared state, grant and transfer-size encodings for sram_like_arbiter.
package arb_pkg;
   typedef enum logic [1:0] {IDLE, ADDR, DATA} state_t;
   typedef enum logic {GNT_INST = 1'b0, GNT_DATA = 1'b1} grant_t;
   localparam logic [1:0] SZ_BYTE = 2'd0;
   localparam logic [1:0] SZ_HALF = 2'd1;
   localparam logic [1:0] SZ_WORD = 2'd2;
endpackage

// File: rtl/sram_like_arbiter_if.sv
// sram_like_arbiter_if: one SRAM-like request/response port; master drives the request side.
interface sram_like_arbiter_if #(parameter int ADDR_W = 32, parameter int DATA_W = 32);
   logic              req;
   logic              wr;
   logic [1:0]        size;
   logic [ADDR_W-1:0] addr;
   logic [DATA_W-1:0] wdata;
   logic [DATA_W-1:0] rdata;
   logic              addr_ok;
   logic              data_ok;
   modport master(output req, wr, size, addr, wdata, input rdata, addr_ok, data_ok);
   modport slave(input req, wr, size, addr, wdata, output rdata, addr_ok, data_ok);
endinterface

// File: rtl/arb_pick.sv
// arb_pick: winner select; a tie goes to the port not named by last_grant_i.
module arb_pick
   import arb_pkg::*;
(
   input  logic   inst_req_i,
   input  logic   data_req_i,
   input  grant_t last_grant_i,
   output grant_t grant_o
);
   assign grant_o = (inst_req_i & data_req_i) ? ((last_grant_i == GNT_INST) ? GNT_DATA : GNT_INST)
                                              : (data_req_i ? GNT_DATA : GNT_INST);
endmodule

// File: rtl/sram_like_arbiter.sv
// sram_like_arbiter: shares one SRAM-like master port between inst and data miss ports.
// Define ARB_FAIR_EN for round-robin ties; otherwise the data port always wins a tie.
module sram_like_arbiter
   import arb_pkg::*;
#(
   parameter int ADDR_W = 32,
   parameter int DATA_W = 32
) (
   input  logic               aclk,
   input  logic               aresetn,
   sram_like_arbiter_if.slave  inst,
   sram_like_arbiter_if.slave  data,
   sram_like_arbiter_if.master m,
   output logic               stall
);
   state_t            state_q, state_d;
   grant_t            grant_q, grant_d, pick, last_grant;
   logic              wr_q, wr_d;
   logic [1:0]        size_q, size_d;
   logic [ADDR_W-1:0] addr_q, addr_d;
   logic [DATA_W-1:0] wdata_q, wdata_d;
   logic              any_req, complete, other_req;

   arb_pick u_pick (
      .inst_req_i  (inst.req),
      .data_req_i  (data.req),
      .last_grant_i(last_grant),
      .grant_o     (pick)
   );

`ifdef ARB_FAIR_EN
   grant_t last_q;
   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) last_q <= GNT_INST;
      else if (state_q == IDLE && any_req) last_q <= pick;
   end
   assign last_grant = last_q;
`else
   assign last_grant = GNT_INST;
`endif

   always_ff @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         state_q <= IDLE;
         grant_q <= GNT_INST;
         wr_q    <= 1'b0;
         size_q  <= 2'd0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         wr_q    <= wr_d;
         size_q  <= size_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      any_req   = inst.req | data.req;
      complete  = m.data_ok & (state_q == DATA | (state_q == ADDR & m.addr_ok));
      other_req = (grant_q == GNT_INST) ? data.req : inst.req;
      state_d   = state_q;
      grant_d   = grant_q;
      wr_d      = wr_q;
      size_d    = size_q;
      addr_d    = addr_q;
      wdata_d   = wdata_q;
      if (state_q == IDLE && any_req) begin
         state_d = ADDR;
         grant_d = pick;
         wr_d    = (pick == GNT_DATA) ? data.wr : inst.wr;
         size_d  = (pick == GNT_DATA) ? data.size : inst.size;
         addr_d  = (pick == GNT_DATA) ? data.addr : inst.addr;
         wdata_d = (pick == GNT_DATA) ? data.wdata : inst.wdata;
      end else if (state_q == ADDR && m.addr_ok) begin
         state_d = m.data_ok ? IDLE : DATA;
      end else if (state_q == DATA && m.data_ok) begin
         state_d = IDLE;
      end
      stall = (state_q != IDLE & ~complete) | (state_q == IDLE & any_req) | (state_q != IDLE & other_req);
   end

   assign m.req        = (state_q == ADDR);
   assign m.wr         = wr_q;
   assign m.size       = size_q;
   assign m.addr       = addr_q;
   assign m.wdata      = wdata_q;
   assign inst.addr_ok = (state_q == ADDR) & m.addr_ok & (grant_q == GNT_INST);
   assign data.addr_ok = (state_q == ADDR) & m.addr_ok & (grant_q == GNT_DATA);
   assign inst.data_ok = complete & (grant_q == GNT_INST);
   assign data.data_ok = complete & (grant_q == GNT_DATA);
   assign inst.rdata   = m.rdata;
   assign data.rdata   = m.rdata;
endmodule

// File: tb/tb_sram_like_arbiter.sv
// tb_sram_like_arbiter: directed stimulus, transaction-level reference model checked every cycle.
module tb_sram_like_arbiter;
   import arb_pkg::*;
`ifdef ARB_FAIR_EN
   localparam bit FAIR = 1'b1;
`else
   localparam bit FAIR = 1'b0;
`endif
   logic aclk = 1'b0;
   logic aresetn = 1'b0;
   logic stall;
   int   checks = 0;
   int   errors = 0;

   sram_like_arbiter_if ii ();
   sram_like_arbiter_if di ();
   sram_like_arbiter_if mi ();

   sram_like_arbiter dut (
      .aclk   (aclk),
      .aresetn(aresetn),
      .inst   (ii),
      .data   (di),
      .m      (mi),
      .stall  (stall)
   );

   always #5 aclk = ~aclk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s got %0h want %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic cyc();
      @(posedge aclk);
      #1;
   endtask

   // Reference: owner -1 = no transaction, 0 = inst, 1 = data; acc = address already accepted
   int          owner = -1;
   bit          acc = 1'b0;
   int          last = 0;
   logic        s_wr = 1'b0;
   logic [1:0]  s_size = 2'd0;
   logic [31:0] s_addr = '0;
   logic [31:0] s_wdata = '0;

   function automatic int winner(input logic i, input logic d);
      if (i && d) return FAIR ? ((last == 1) ? 0 : 1) : 1;
      return d ? 1 : 0;
   endfunction

   always @(posedge aclk or negedge aresetn) begin
      if (!aresetn) begin
         owner   <= -1;
         acc     <= 1'b0;
         last    <= 0;
         s_wr    <= 1'b0;
         s_size  <= 2'd0;
         s_addr  <= '0;
         s_wdata <= '0;
      end else if (owner < 0) begin
         if (ii.req || di.req) begin
            owner   <= winner(ii.req, di.req);
            last    <= winner(ii.req, di.req);
            acc     <= 1'b0;
            s_wr    <= (winner(ii.req, di.req) == 1) ? di.wr : ii.wr;
            s_size  <= (winner(ii.req, di.req) == 1) ? di.size : ii.size;
            s_addr  <= (winner(ii.req, di.req) == 1) ? di.addr : ii.addr;
            s_wdata <= (winner(ii.req, di.req) == 1) ? di.wdata : ii.wdata;
         end
      end else if (!acc) begin
         if (mi.addr_ok) begin
            if (mi.data_ok) owner <= -1;
            else acc <= 1'b1;
         end
      end else if (mi.data_ok) begin
         owner <= -1;
      end
   end

   always @(negedge aclk) begin
      logic done;
      done = (owner >= 0) && mi.data_ok && (acc || mi.addr_ok);
      chk("m_req", 32'(mi.req), 32'(owner >= 0 && !acc));
      chk("m_wr", 32'(mi.wr), 32'(s_wr));
      chk("m_size", 32'(mi.size), 32'(s_size));
      chk("m_addr", mi.addr, s_addr);
      chk("m_wdata", mi.wdata, s_wdata);
      chk("inst_addr_ok", 32'(ii.addr_ok), 32'(owner == 0 && !acc && mi.addr_ok));
      chk("data_addr_ok", 32'(di.addr_ok), 32'(owner == 1 && !acc && mi.addr_ok));
      chk("inst_data_ok", 32'(ii.data_ok), 32'(owner == 0 && done));
      chk("data_data_ok", 32'(di.data_ok), 32'(owner == 1 && done));
      chk("inst_rdata", ii.rdata, mi.rdata);
      chk("data_rdata", di.rdata, mi.rdata);
      chk("stall", 32'(stall), 32'((owner < 0) ? (ii.req | di.req)
                                   : (!done || ((owner == 0) ? di.req : ii.req))));
   end

   logic [31:0] fair_exp [4];
   initial begin
      {ii.req, ii.wr, ii.size, ii.addr, ii.wdata} = '0;
      {di.req, di.wr, di.size, di.addr, di.wdata} = '0;
      {mi.rdata, mi.addr_ok, mi.data_ok} = '0;
      repeat (2) cyc();
      chk("rst_m_req", 32'(mi.req), 32'd0);
      chk("rst_m_addr", mi.addr, 32'd0);
      chk("rst_stall", 32'(stall), 32'd0);
      aresetn = 1'b1;
      // single inst read
      cyc(); ii.req = 1'b1; ii.addr = 32'hBFC00000; ii.size = SZ_WORD;
      #3 chk("t1_c1_m_req", 32'(mi.req), 32'd0); chk("t1_c1_stall", 32'(stall), 32'd1);
      cyc();
      #3 chk("t1_c2_m_req", 32'(mi.req), 32'd1); chk("t1_c2_m_addr", mi.addr, 32'hBFC00000);
      chk("t1_c2_m_size", 32'(mi.size), 32'd2);
      cyc(); mi.addr_ok = 1'b1;
      #3 chk("t1_c3_inst_addr_ok", 32'(ii.addr_ok), 32'd1); chk("t1_c3_data_addr_ok", 32'(di.addr_ok), 32'd0);
      cyc(); mi.addr_ok = 1'b0; ii.req = 1'b0;
      #3 chk("t1_c4_m_req", 32'(mi.req), 32'd0); chk("t1_c4_stall", 32'(stall), 32'd1);
      cyc(); mi.data_ok = 1'b1; mi.rdata = 32'h3C080000;
      #3 chk("t1_c5_inst_data_ok", 32'(ii.data_ok), 32'd1); chk("t1_c5_rdata", ii.rdata, 32'h3C080000);
      cyc(); mi.data_ok = 1'b0;
      #3 chk("t1_c6_stall", 32'(stall), 32'd0); chk("t1_c6_inst_data_ok", 32'(ii.data_ok), 32'd0);
      // simultaneous requests: data first, inst after the bubble
      cyc(); ii.req = 1'b1; ii.addr = 32'h00400000;
      di.req = 1'b1; di.wr = 1'b1; di.addr = 32'h80001000; di.wdata = 32'hDEADBEEF; di.size = SZ_WORD;
      #3 chk("t2_c1_stall", 32'(stall), 32'd1);
      cyc();
      #3 chk("t2_c2_m_wr", 32'(mi.wr), 32'd1); chk("t2_c2_m_addr", mi.addr, 32'h80001000);
      chk("t2_c2_m_wdata", mi.wdata, 32'hDEADBEEF);
      cyc(); mi.addr_ok = 1'b1;
      #3 chk("t2_c3_data_addr_ok", 32'(di.addr_ok), 32'd1); chk("t2_c3_inst_addr_ok", 32'(ii.addr_ok), 32'd0);
      cyc(); mi.addr_ok = 1'b0; di.req = 1'b0; di.wr = 1'b0; mi.data_ok = 1'b1;
      #3 chk("t2_c4_data_data_ok", 32'(di.data_ok), 32'd1); chk("t2_c4_stall", 32'(stall), 32'd1);
      cyc(); mi.data_ok = 1'b0;
      #3 chk("t2_c5_m_req", 32'(mi.req), 32'd0); chk("t2_c5_stall", 32'(stall), 32'd1);
      cyc(); mi.addr_ok = 1'b1; mi.data_ok = 1'b1; mi.rdata = 32'h24020001;
      #3 chk("t2_c6_m_addr", mi.addr, 32'h00400000); chk("t2_c6_m_wr", 32'(mi.wr), 32'd0);
      chk("t2_c6_inst_addr_ok", 32'(ii.addr_ok), 32'd1); chk("t2_c6_inst_data_ok", 32'(ii.data_ok), 32'd1);
      cyc(); {mi.addr_ok, mi.data_ok} = '0; ii.req = 1'b0;
      #3 chk("t2_c7_m_req", 32'(mi.req), 32'd0); chk("t2_c7_stall", 32'(stall), 32'd0);
      // data read with address and data accepted together
      cyc(); di.req = 1'b1; di.addr = 32'h80002000;
      cyc(); mi.addr_ok = 1'b1; mi.data_ok = 1'b1; mi.rdata = 32'h12345678;
      #3 chk("t3_data_addr_ok", 32'(di.addr_ok), 32'd1); chk("t3_data_data_ok", 32'(di.data_ok), 32'd1);
      chk("t3_rdata", di.rdata, 32'h12345678); chk("t3_stall", 32'(stall), 32'd0);
      cyc(); {mi.addr_ok, mi.data_ok} = '0; di.req = 1'b0;
      #3 chk("t3_idle_m_req", 32'(mi.req), 32'd0);
      // reset while waiting for data, inst request still pending
      cyc(); ii.req = 1'b1; ii.addr = 32'hBFC00100;
      cyc(); mi.addr_ok = 1'b1;
      cyc(); mi.addr_ok = 1'b0; mi.data_ok = 1'b1;
      #1 aresetn = 1'b0;
      #1 chk("t5_rst_m_req", 32'(mi.req), 32'd0); chk("t5_rst_inst_data_ok", 32'(ii.data_ok), 32'd0);
      chk("t5_rst_inst_addr_ok", 32'(ii.addr_ok), 32'd0); chk("t5_rst_m_addr", mi.addr, 32'd0);
      mi.data_ok = 1'b0;
      cyc(); aresetn = 1'b1;
      cyc(); mi.addr_ok = 1'b1; mi.data_ok = 1'b1;
      #3 chk("t5_regrant_m_req", 32'(mi.req), 32'd1); chk("t5_regrant_m_addr", mi.addr, 32'hBFC00100);
      chk("t5_regrant_inst_data_ok", 32'(ii.data_ok), 32'd1);
      cyc(); {mi.addr_ok, mi.data_ok} = '0; ii.req = 1'b0;
      // both ports requesting continuously for four transactions
      fair_exp = FAIR ? '{32'h2000, 32'h1000, 32'h2000, 32'h1000} : '{32'h2000, 32'h2000, 32'h2000, 32'h2000};
      ii.req = 1'b1; ii.addr = 32'h1000; di.req = 1'b1; di.addr = 32'h2000;
      for (int k = 0; k < 4; k++) begin
         int n;
         n = 0;
         while (!mi.req && n < 20) begin cyc(); n++; end
         chk("t4_grant_timeout", 32'(mi.req), 32'd1);
         chk($sformatf("t4_grant%0d_addr", k), mi.addr, fair_exp[k]);
         mi.addr_ok = 1'b1;
         cyc(); mi.addr_ok = 1'b0; mi.data_ok = 1'b1;
         if (k == 3) {ii.req, di.req} = '0;
         cyc(); mi.data_ok = 1'b0;
      end
      // stray responses while idle
      cyc(); mi.data_ok = 1'b1; mi.addr_ok = 1'b1;
      #3 chk("t6_inst_data_ok", 32'(ii.data_ok), 32'd0); chk("t6_data_data_ok", 32'(di.data_ok), 32'd0);
      chk("t6_stall", 32'(stall), 32'd0);
      cyc(); {mi.addr_ok, mi.data_ok} = '0;
      #3 chk("t6_m_req", 32'(mi.req), 32'd0);
      repeat (3) cyc();
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule

// File: doc/sram_like_arbiter.md
Name: sram_like_arbiter

Overview:
- 2:1 arbiter/sequencer sharing one SRAM-like master port between the instruction-cache and data-cache miss ports.
- Sits between the cache block and the AXI bridge.
- One outstanding transaction at a time.
- Generates the cache-side stall while any request is pending or in flight.

Parameters:
ADDR_W, 32, address width
DATA_W, 32, read/write data width

Ports:
aclk  in  1  clock, rising edge
aresetn  in  1  asynchronous active-low reset
inst_req  in  1  inst request, held until inst_addr_ok
inst_wr  in  1  inst write flag (normally 0)
inst_size  in  2  0=byte, 1=half, 2=word
inst_addr  in  ADDR_W  inst address
inst_wdata  in  DATA_W  inst write data
inst_rdata  out  DATA_W  read data, valid with inst_data_ok
inst_addr_ok  out  1  inst address accepted
inst_data_ok  out  1  inst transaction done
data_req, data_wr, data_size, data_addr, data_wdata  in  same as inst_*  data-port request
data_rdata, data_addr_ok, data_data_ok  out  same as inst_*  data-port response
m_req  out  1  master request
m_wr  out  1  master write
m_size  out  2  master size
m_addr  out  ADDR_W  master address
m_wdata  out  DATA_W  master write data
m_rdata  in  DATA_W  master read data
m_addr_ok  in  1  master address accepted
m_data_ok  in  1  master transaction done
stall  out  1  stall to cache/pipeline

Behaviour:
- Interface: one clock `aclk`; reset `aresetn` is asynchronous, active-low.
- Reset values: state=IDLE; grant=INST; m_req=0; m_wr=0; m_size=0; m_addr=0; m_wdata=0; last_grant=INST; all *_addr_ok and *_data_ok = 0.
- FSM states: IDLE, ADDR, DATA.
- IDLE:
  - data_req=1 → grant DATA. Else inst_req=1 → grant INST.
  - On grant, register the winner's wr/size/addr/wdata into the m_* registers. Next state ADDR.
  - m_data_ok/m_addr_ok in IDLE are ignored.
- ADDR:
  - m_req=1 and m_* fields stay stable until m_addr_ok.
  - In the m_addr_ok cycle, forward it combinationally to the granted port's *_addr_ok only.
  - m_addr_ok alone → DATA; m_req=0 from the next cycle.
  - m_addr_ok and m_data_ok in the same cycle → complete immediately (both oks pulsed) and go to IDLE.
- DATA:
  - m_req=0. Wait for m_data_ok.
  - On m_data_ok, pulse the granted port's *_data_ok (combinational, same cycle) and go to IDLE.
- Read data: m_rdata is forwarded to both *_rdata unmodified; only *_data_ok qualifies it.
- Latency: grant registered. m_req rises 1 cycle after the req is seen in IDLE. Minimum back-to-back spacing: complete → IDLE → ADDR, giving a 1-cycle bubble.
- Losing requester: its req stays high and is arbitrated in the next IDLE. It never receives an addr_ok while the other port is granted.
- stall: `stall = (state!=IDLE & ~complete) | (state==IDLE & (inst_req|data_req)) | (state!=IDLE & other_req)`.
  - other_req is the non-granted port's req.
  - `complete` = m_data_ok in DATA, or m_addr_ok & m_data_ok in ADDR.
- Reset mid-transaction: returns to IDLE and abandons the transaction. The downstream bridge must share aresetn.

Optional Feature:
- ARB_FAIR_EN defined:
  - Round-robin on ties. A last_grant register is updated at every grant.
  - When both reqs are high in IDLE, grant the port not last granted.
  - last_grant resets to INST, so the first tie goes to DATA.
- ARB_FAIR_EN undefined: fixed priority, DATA always wins; last_grant is absent.

Decomposition:
- Shared package `arb_pkg` holds:
  - state encoding (IDLE/ADDR/DATA);
  - grant encoding (GNT_INST=0, GNT_DATA=1);
  - size constants (SZ_BYTE/SZ_HALF/SZ_WORD).
- One natural sub-module: `arb_pick`, a combinational winner select taking (inst_req, data_req, last_grant) and producing grant. The FSM and registers stay in the top.

Test Plan:
- Single inst read: inst_req=1, addr=0xBFC00000, size=2; m_addr_ok on cycle 3, m_data_ok=1 with m_rdata=0x3C080000 on cycle 5 → m_req=1 cycles 2–3; inst_addr_ok cycle 3; inst_data_ok cycle 5 with rdata 0x3C080000; stall low from cycle 6.
- Simultaneous reqs, fixed priority: both req at cycle 1 (data write 0x80001000, wdata 0xDEADBEEF, size 2) → data granted first (m_wr=1, m_addr=0x80001000). Inst is granted after the data transaction completes plus the 1-cycle IDLE bubble. stall stays high throughout.
- ARB_FAIR_EN: both ports request continuously for 4 transactions → grant order DATA, INST, DATA, INST.
- Same-cycle addr_ok+data_ok in ADDR: data read with m_addr_ok=m_data_ok=1 → data_addr_ok and data_data_ok both pulse that cycle; next state IDLE.
- Reset mid-op: assert aresetn=0 while in DATA → m_req=0, all oks=0 asynchronously. After release, a pending inst_req is regranted normally.
- Stray m_data_ok in IDLE with no reqs → no *_data_ok pulse, stall=0.
